// File: rtl/match_game_ctrl.sv
// Sequencer for the colour-matching memory game. It walks three levels of
// growing board size, reveals up to two cards per turn, keeps matched pairs
// face-up and hides mismatched pairs again after a hold time.
module match_game_ctrl #(
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned DONE_CYCLES = 50000000,
  parameter int unsigned TMR_W       = 26
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        key_valid,
  input  logic [3:0]  key_idx,
  output logic [2:0]  level,
  output logic [11:0] reveal,
  output logic [7:0]  moves,
  output logic        busy,
  output logic        game_done
);

  // Controller states
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PICK1      = 3'd1;
  localparam logic [2:0] ST_PICK2      = 3'd2;
  localparam logic [2:0] ST_COMPARE    = 3'd3;
  localparam logic [2:0] ST_HOLD       = 3'd4;
  localparam logic [2:0] ST_LEVEL_DONE = 3'd5;
  localparam logic [2:0] ST_GAME_DONE  = 3'd6;

  // One-hot level encodings as seen by the display datapath
  localparam logic [2:0] LVL_NONE = 3'b000;
  localparam logic [2:0] LVL_1    = 3'b001;
  localparam logic [2:0] LVL_2    = 3'b010;
  localparam logic [2:0] LVL_3    = 3'b100;

  // Timer reload values; the timer counts down to zero inclusive, so a load
  // of N-1 gives exactly N cycles in the timed state.
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] DONE_LOAD = TMR_W'(DONE_CYCLES - 1);

  // Cards that exist on the board at a given level
  function automatic logic [11:0] active_set(input logic [2:0] lvl);
    logic [11:0] m;
    m = 12'h000;
    case (lvl)
      LVL_1:   m = 12'h033;  // 0,1,4,5
      LVL_2:   m = 12'h077;  // 0,1,2,4,5,6
      LVL_3:   m = 12'hFFF;  // 0..11
      default: m = 12'h000;
    endcase
    return m;
  endfunction

  // Fixed pairing of cards per level; 4'hF means "no partner"
  function automatic logic [3:0] partner(input logic [2:0] lvl, input logic [3:0] idx);
    logic [3:0] p;
    p = 4'hF;
    case (lvl)
      LVL_1: begin
        case (idx)
          4'd0:    p = 4'd5;
          4'd5:    p = 4'd0;
          4'd1:    p = 4'd4;
          4'd4:    p = 4'd1;
          default: p = 4'hF;
        endcase
      end
      LVL_2: begin
        case (idx)
          4'd0:    p = 4'd5;
          4'd5:    p = 4'd0;
          4'd1:    p = 4'd2;
          4'd2:    p = 4'd1;
          4'd4:    p = 4'd6;
          4'd6:    p = 4'd4;
          default: p = 4'hF;
        endcase
      end
      LVL_3: begin
        case (idx)
          4'd0:    p = 4'd4;
          4'd4:    p = 4'd0;
          4'd1:    p = 4'd10;
          4'd10:   p = 4'd1;
          4'd2:    p = 4'd8;
          4'd8:    p = 4'd2;
          4'd3:    p = 4'd6;
          4'd6:    p = 4'd3;
          4'd7:    p = 4'd9;
          4'd9:    p = 4'd7;
          4'd5:    p = 4'd11;
          4'd11:   p = 4'd5;
          default: p = 4'hF;
        endcase
      end
      default: p = 4'hF;
    endcase
    return p;
  endfunction

  logic [2:0]       state_reg, state_next;
  logic [2:0]       level_reg, level_next;
  logic [11:0]      reveal_reg, reveal_next;
  logic [7:0]       moves_reg, moves_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [3:0]       first_reg, first_next;
  logic [3:0]       second_reg, second_next;
  logic             busy_reg, busy_next;
  logic             game_done_reg, game_done_next;

  // One-hot decodes of the key index and of the two cards of the turn.
  // Indices 12..15 decode to all zeros and therefore never match a card.
  logic [11:0] key_hit;
  logic [11:0] first_hit;
  logic [11:0] second_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_dec
      assign key_hit[gi]    = (key_idx    == 4'(gi));
      assign first_hit[gi]  = (first_reg  == 4'(gi));
      assign second_hit[gi] = (second_reg == 4'(gi));
    end
  endgenerate

  logic [11:0] active_mask;
  logic        key_ok;
  logic        pair_ok;
  logic        board_full;
  logic [7:0]  moves_inc;

  assign active_mask = active_set(level_reg);
  // A key counts only if it names an active card that is still face-down
  assign key_ok      = key_valid && (|(key_hit & active_mask & ~reveal_reg));
  assign pair_ok     = (partner(level_reg, first_reg) == second_reg);
  assign board_full  = ((reveal_reg & active_mask) == active_mask);
  assign moves_inc   = (moves_reg == 8'hFF) ? moves_reg : (moves_reg + 8'd1);

  // Next-state and datapath update for the game sequencer
  always_comb begin
    state_next  = state_reg;
    level_next  = level_reg;
    reveal_next = reveal_reg;
    moves_next  = moves_reg;
    timer_next  = timer_reg;
    first_next  = first_reg;
    second_next = second_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          level_next  = LVL_1;
          reveal_next = 12'h000;
          moves_next  = 8'd0;
          state_next  = ST_PICK1;
        end
      end

      ST_PICK1: begin
        if (key_ok) begin
          reveal_next = reveal_reg | key_hit;
          first_next  = key_idx;
          state_next  = ST_PICK2;
        end
      end

      ST_PICK2: begin
        if (key_ok) begin
          reveal_next = reveal_reg | key_hit;
          second_next = key_idx;
          moves_next  = moves_inc;
          state_next  = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        // reveal_reg already includes the second card at this point
        if (pair_ok && board_full) begin
          timer_next = DONE_LOAD;
          state_next = ST_LEVEL_DONE;
        end else if (pair_ok) begin
          state_next = ST_PICK1;
        end else begin
          timer_next = HOLD_LOAD;
          state_next = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (timer_reg == '0) begin
          reveal_next = reveal_reg & ~(first_hit | second_hit);
          state_next  = ST_PICK1;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end

      ST_LEVEL_DONE: begin
        if (timer_reg == '0) begin
          case (level_reg)
            LVL_1: begin
              level_next  = LVL_2;
              reveal_next = 12'h000;
              moves_next  = 8'd0;
              state_next  = ST_PICK1;
            end
            LVL_2: begin
              level_next  = LVL_3;
              reveal_next = 12'h000;
              moves_next  = 8'd0;
              state_next  = ST_PICK1;
            end
            default: begin
              state_next = ST_GAME_DONE;
            end
          endcase
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end

      ST_GAME_DONE: begin
        if (start) begin
          level_next  = LVL_1;
          reveal_next = 12'h000;
          moves_next  = 8'd0;
          state_next  = ST_PICK1;
        end
      end

      default: begin
        // Unreachable encodings fall back to a clean idle board
        level_next  = LVL_NONE;
        reveal_next = 12'h000;
        moves_next  = 8'd0;
        timer_next  = '0;
        state_next  = ST_IDLE;
      end
    endcase
  end

  // Status flags are derived from the next state so they register alongside it
  always_comb begin
    busy_next      = (state_next == ST_COMPARE) || (state_next == ST_HOLD) ||
                     (state_next == ST_LEVEL_DONE);
    game_done_next = (state_next == ST_GAME_DONE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      level_reg     <= LVL_NONE;
      reveal_reg    <= 12'h000;
      moves_reg     <= 8'd0;
      timer_reg     <= '0;
      first_reg     <= 4'd0;
      second_reg    <= 4'd0;
      busy_reg      <= 1'b0;
      game_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      level_reg     <= level_next;
      reveal_reg    <= reveal_next;
      moves_reg     <= moves_next;
      timer_reg     <= timer_next;
      first_reg     <= first_next;
      second_reg    <= second_next;
      busy_reg      <= busy_next;
      game_done_reg <= game_done_next;
    end
  end

  assign level     = level_reg;
  assign reveal    = reveal_reg;
  assign moves     = moves_reg;
  assign busy      = busy_reg;
  assign game_done = game_done_reg;

endmodule

// File: tb/tb_match_game_ctrl.sv
// Directed bench for match_game_ctrl: a table of one-cycle vectors walks
// level 1 and part of level 2, then hand-written sequences cover reset
// mid-hold, full game completion, restart and move-counter saturation.
module tb_match_game_ctrl;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        key_valid;
  logic [3:0]  key_idx;
  logic [2:0]  level;
  logic [11:0] reveal;
  logic [7:0]  moves;
  logic        busy;
  logic        game_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  match_game_ctrl #(
    .HOLD_CYCLES(4),
    .DONE_CYCLES(3),
    .TMR_W(26)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .key_valid(key_valid),
    .key_idx(key_idx),
    .level(level),
    .reveal(reveal),
    .moves(moves),
    .busy(busy),
    .game_done(game_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         st;
    bit         kv;
    logic [3:0] idx;
    logic [2:0] exp_level;
    logic [11:0] exp_reveal;
    logic [7:0] exp_moves;
    bit         exp_busy;
    bit         exp_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, bit st, bit kv, logic [3:0] idx,
                              logic [2:0] l, logic [11:0] r, logic [7:0] m,
                              bit b, bit d);
    vec_t v;
    v.name = n; v.st = st; v.kv = kv; v.idx = idx;
    v.exp_level = l; v.exp_reveal = r; v.exp_moves = m;
    v.exp_busy = b; v.exp_done = d;
    return v;
  endfunction

  // Apply inputs for exactly one rising edge, then sample 1 ns later
  task automatic cycle(input bit st, input bit kv, input logic [3:0] idx);
    start = st; key_valid = kv; key_idx = idx;
    @(posedge clk);
    #1;
    start = 1'b0; key_valid = 1'b0; key_idx = 4'd0;
  endtask

  // Compare all outputs against one expected record
  task automatic chk(string name, logic [2:0] l, logic [11:0] r, logic [7:0] m,
                     bit b, bit d);
    total_cnt++;
    if (level === l && reveal === r && moves === m && busy === b && game_done === d) begin
      pass_cnt++;
      $display("ok   %s: level=%b reveal=%h moves=%0d busy=%b done=%b",
               name, level, reveal, moves, busy, game_done);
    end else begin
      $display("FAIL %s: got level=%b reveal=%h moves=%0d busy=%b done=%b, want level=%b reveal=%h moves=%0d busy=%b done=%b",
               name, level, reveal, moves, busy, game_done, l, r, m, b, d);
    end
  endtask

  // Play one turn: two keys then the compare cycle
  task automatic pair(input logic [3:0] a, input logic [3:0] b);
    cycle(1'b0, 1'b1, a);
    cycle(1'b0, 1'b1, b);
    cycle(1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; key_valid = 1'b0; key_idx = 4'd0;

    // Level 1: mismatch with hold, first pair, repeat key, completion
    tbl.push_back(mk("l1_start",   1,0,4'd0,  3'b001,12'h000,8'd0,0,0));
    tbl.push_back(mk("l1_k0",      0,1,4'd0,  3'b001,12'h001,8'd0,0,0));
    tbl.push_back(mk("l1_k4_cmp",  0,1,4'd4,  3'b001,12'h011,8'd1,1,0));
    tbl.push_back(mk("l1_hold_k1", 0,1,4'd1,  3'b001,12'h011,8'd1,1,0));
    tbl.push_back(mk("l1_hold2",   0,0,4'd0,  3'b001,12'h011,8'd1,1,0));
    tbl.push_back(mk("l1_hold3",   0,0,4'd0,  3'b001,12'h011,8'd1,1,0));
    tbl.push_back(mk("l1_hold4",   0,0,4'd0,  3'b001,12'h011,8'd1,1,0));
    tbl.push_back(mk("l1_hide",    0,0,4'd0,  3'b001,12'h000,8'd1,0,0));
    tbl.push_back(mk("l1_k0b",     0,1,4'd0,  3'b001,12'h001,8'd1,0,0));
    tbl.push_back(mk("l1_k5",      0,1,4'd5,  3'b001,12'h021,8'd2,1,0));
    tbl.push_back(mk("l1_match",   0,0,4'd0,  3'b001,12'h021,8'd2,0,0));
    tbl.push_back(mk("l1_rep0",    0,1,4'd0,  3'b001,12'h021,8'd2,0,0));
    tbl.push_back(mk("l1_k1",      0,1,4'd1,  3'b001,12'h023,8'd2,0,0));
    tbl.push_back(mk("l1_k4_last", 0,1,4'd4,  3'b001,12'h033,8'd3,1,0));
    tbl.push_back(mk("l1_done1",   1,1,4'd2,  3'b001,12'h033,8'd3,1,0));
    tbl.push_back(mk("l1_done2",   0,0,4'd0,  3'b001,12'h033,8'd3,1,0));
    tbl.push_back(mk("l1_done3",   0,1,4'd2,  3'b001,12'h033,8'd3,1,0));
    tbl.push_back(mk("l2_enter",   0,0,4'd0,  3'b010,12'h000,8'd0,0,0));
    // Level 2: ignored keys, mismatch, start ignored, a pair
    tbl.push_back(mk("l2_k3",      0,1,4'd3,  3'b010,12'h000,8'd0,0,0));
    tbl.push_back(mk("l2_k12",     0,1,4'd12, 3'b010,12'h000,8'd0,0,0));
    tbl.push_back(mk("l2_k15",     0,1,4'd15, 3'b010,12'h000,8'd0,0,0));
    tbl.push_back(mk("l2_k0",      0,1,4'd0,  3'b010,12'h001,8'd0,0,0));
    tbl.push_back(mk("l2_rep0",    0,1,4'd0,  3'b010,12'h001,8'd0,0,0));
    tbl.push_back(mk("l2_k8",      0,1,4'd8,  3'b010,12'h001,8'd0,0,0));
    tbl.push_back(mk("l2_k2_cmp",  0,1,4'd2,  3'b010,12'h005,8'd1,1,0));
    tbl.push_back(mk("l2_hold1",   0,0,4'd0,  3'b010,12'h005,8'd1,1,0));
    tbl.push_back(mk("l2_hold2",   0,0,4'd0,  3'b010,12'h005,8'd1,1,0));
    tbl.push_back(mk("l2_hold3",   0,0,4'd0,  3'b010,12'h005,8'd1,1,0));
    tbl.push_back(mk("l2_hold4",   0,0,4'd0,  3'b010,12'h005,8'd1,1,0));
    tbl.push_back(mk("l2_hide",    0,0,4'd0,  3'b010,12'h000,8'd1,0,0));
    tbl.push_back(mk("l2_start_x", 1,0,4'd0,  3'b010,12'h000,8'd1,0,0));
    tbl.push_back(mk("l2_k4",      0,1,4'd4,  3'b010,12'h010,8'd1,0,0));
    tbl.push_back(mk("l2_k6",      0,1,4'd6,  3'b010,12'h050,8'd2,1,0));
    tbl.push_back(mk("l2_match",   0,0,4'd0,  3'b010,12'h050,8'd2,0,0));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", 3'b000, 12'h000, 8'd0, 0, 0);
    resetn = 1'b1;
    cycle(1'b0, 1'b1, 4'd0);
    chk("idle_key_ignored", 3'b000, 12'h000, 8'd0, 0, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].st, tbl[i].kv, tbl[i].idx);
      chk(tbl[i].name, tbl[i].exp_level, tbl[i].exp_reveal, tbl[i].exp_moves,
          tbl[i].exp_busy, tbl[i].exp_done);
    end

    // Reset asserted in the middle of a level 2 hold
    cycle(1'b0, 1'b1, 4'd1);
    cycle(1'b0, 1'b1, 4'd0);
    chk("l2_mis_cmp", 3'b010, 12'h053, 8'd3, 1, 0);
    cycle(1'b0, 1'b0, 4'd0);
    cycle(1'b0, 1'b0, 4'd0);
    chk("l2_in_hold", 3'b010, 12'h053, 8'd3, 1, 0);
    resetn = 1'b0;
    cycle(1'b0, 1'b0, 4'd0);
    chk("reset_mid_hold", 3'b000, 12'h000, 8'd0, 0, 0);
    resetn = 1'b1;

    // Full game: L1, L2, L3
    cycle(1'b1, 1'b0, 4'd0);
    chk("restart_l1", 3'b001, 12'h000, 8'd0, 0, 0);
    pair(4'd0, 4'd5);
    pair(4'd1, 4'd4);
    repeat (3) cycle(1'b0, 1'b0, 4'd0);
    chk("adv_l2", 3'b010, 12'h000, 8'd0, 0, 0);
    pair(4'd0, 4'd5);
    pair(4'd1, 4'd2);
    pair(4'd4, 4'd6);
    chk("l2_full_done", 3'b010, 12'h077, 8'd3, 1, 0);
    repeat (3) cycle(1'b0, 1'b0, 4'd0);
    chk("adv_l3", 3'b100, 12'h000, 8'd0, 0, 0);
    pair(4'd0, 4'd4);
    pair(4'd1, 4'd10);
    pair(4'd2, 4'd8);
    pair(4'd3, 4'd6);
    pair(4'd7, 4'd9);
    chk("l3_five_pairs", 3'b100, 12'h7DF, 8'd5, 0, 0);
    pair(4'd5, 4'd11);
    chk("l3_level_done", 3'b100, 12'hFFF, 8'd6, 1, 0);
    repeat (3) cycle(1'b0, 1'b0, 4'd0);
    chk("game_done", 3'b100, 12'hFFF, 8'd6, 0, 1);
    cycle(1'b0, 1'b1, 4'd0);
    chk("game_done_key_ignored", 3'b100, 12'hFFF, 8'd6, 0, 1);
    cycle(1'b1, 1'b1, 4'd0);
    chk("restart_key_dropped", 3'b001, 12'h000, 8'd0, 0, 0);
    cycle(1'b0, 1'b1, 4'd0);
    chk("restart_pick1", 3'b001, 12'h001, 8'd0, 0, 0);

    // Moves saturation: 300 mismatched turns (0 then 4)
    cycle(1'b0, 1'b1, 4'd4);
    repeat (5) cycle(1'b0, 1'b0, 4'd0);
    chk("sat_turn1", 3'b001, 12'h000, 8'd1, 0, 0);
    for (int t = 0; t < 253; t++) begin
      cycle(1'b0, 1'b1, 4'd0);
      cycle(1'b0, 1'b1, 4'd4);
      repeat (5) cycle(1'b0, 1'b0, 4'd0);
    end
    chk("sat_254", 3'b001, 12'h000, 8'd254, 0, 0);
    cycle(1'b0, 1'b1, 4'd0);
    cycle(1'b0, 1'b1, 4'd4);
    repeat (5) cycle(1'b0, 1'b0, 4'd0);
    chk("sat_255", 3'b001, 12'h000, 8'd255, 0, 0);
    for (int t = 0; t < 45; t++) begin
      cycle(1'b0, 1'b1, 4'd0);
      cycle(1'b0, 1'b1, 4'd4);
      repeat (5) cycle(1'b0, 1'b0, 4'd0);
    end
    chk("sat_300", 3'b001, 12'h000, 8'd255, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/match_game_ctrl.md
Name: match_game_ctrl

Overview:
- Game sequencer for the colour-matching memory game.
- Drives the card-display datapath through a one-hot level select and a 12-bit card reveal vector.
- Accepts decoded key presses and lets the player flip two cards per turn. Matched pairs stay revealed; mismatched pairs are hidden again after a hold time.
- Advances level 1 (2x2) to level 2 (3x2) to level 3 (4x3), then flags game completion.

Parameters:
HOLD_CYCLES, 25000000, cycles a mismatched pair stays visible (0.5 s at 50 MHz); must be >= 1
DONE_CYCLES, 50000000, cycles the completed board is shown before the level advances; must be >= 1
TMR_W, 26, timer width; must hold max(HOLD_CYCLES, DONE_CYCLES)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
start  in  1  single-cycle pulse; starts or restarts the game
key_valid  in  1  single-cycle pulse; key_idx is valid
key_idx  in  4  card index: 0..3 = q,w,e,r; 4..7 = a,s,d,f; 8..11 = z,x,c,v
level  out  3  000 = idle/wipe, 001 = L1, 010 = L2, 100 = L3
reveal  out  12  bit i = card key_idx i is face-up
moves  out  8  turns taken this level, saturating at 255
busy  out  1  high in COMPARE, HOLD and LEVEL_DONE (input ignored)
game_done  out  1  high in GAME_DONE

Behaviour:
Reset and clocking:
- Reset is clk and resetn, synchronous, active-low. It takes effect at the next edge from any state, including mid-HOLD.
- Reset values: state IDLE, level 000, reveal 0, moves 0, busy 0, game_done 0, timer 0, first 0, second 0.
- All outputs are registered.

Active card sets:
- L1: {0,1,4,5}
- L2: {0,1,2,4,5,6}
- L3: {0..11}

Fixed pair table (the partner relation is symmetric):
- L1: 0-5, 1-4
- L2: 0-5, 1-2, 4-6
- L3: 0-4, 1-10, 2-8, 3-6, 7-9, 5-11

Valid key:
- A key is valid when key_valid=1, key_idx is in the active set of the current level, and reveal[key_idx]=0.
- Any other key (idx > 11, inactive card, already face-up card) is ignored with no state change.

States:
- IDLE: level=000, which makes the display wipe. On start: level<=001, reveal<=0, moves<=0, go to PICK1.
- PICK1: on a valid key: reveal[idx]<=1, first<=idx, go to PICK2.
- PICK2: on a valid key: reveal[idx]<=1, second<=idx, moves<=moves+1 (hold at 255), go to COMPARE.
- COMPARE (exactly 1 cycle):
  - If partner(first)==second and every active card is revealed (checked on the updated reveal vector): timer<=DONE_CYCLES-1, go to LEVEL_DONE.
  - Else if partner(first)==second: go to PICK1.
  - Else: timer<=HOLD_CYCLES-1, go to HOLD.
- HOLD: timer decrements each cycle. On the cycle timer==0: clear reveal[first] and reveal[second], go to PICK1. A mismatched pair is visible for exactly HOLD_CYCLES cycles after COMPARE.
- LEVEL_DONE: timer decrements each cycle. When timer==0:
  - level 001 -> 010, or 010 -> 100; reveal<=0, moves<=0, go to PICK1.
  - level 100 -> GAME_DONE.
- GAME_DONE: level stays 100, reveal stays all ones, game_done=1. On start: level<=001, reveal<=0, moves<=0, go to PICK1.

Timing:
- Key-to-reveal latency: 1 cycle. Turn resolution after the second key: 1 cycle (COMPARE).

Ignored inputs and simultaneous events:
- start is ignored in PICK1, PICK2, COMPARE, HOLD and LEVEL_DONE. A restart mid-game requires resetn.
- key_valid is ignored in IDLE, COMPARE, HOLD, LEVEL_DONE and GAME_DONE. Keys are not queued.
- start and key_valid in the same cycle in IDLE or GAME_DONE: start wins and the key is dropped.
- Pressing the same card twice in PICK2: ignored, because that card is already revealed.

Test Plan:
All tests use HOLD_CYCLES=4 and DONE_CYCLES=3.
- Reset, then start -> level=001, reveal=000, PICK1. Key 0 -> next cycle reveal=001. Key 5 -> reveal=021 (bits 0 and 5), moves=1. After COMPARE, state is PICK1 and reveal stays 021.
- L1 mismatch: keys 0 then 4 -> reveal=011, busy=1 for 1+4 cycles, then reveal=000, moves=1. Key 1 pressed during HOLD -> no effect.
- L1 completion: pairs 0/5 and 1/4 -> LEVEL_DONE with reveal=033 for 3 cycles, then level=010, reveal=000, moves=0.
- Ignored keys in L2: key 3, key 12, and repeat key 0 while bit 0 is set -> reveal unchanged, state unchanged.
- Full L3 with all six correct pairs -> after DONE_CYCLES: game_done=1, level=100, reveal=FFF. Then start -> level=001, reveal=000, moves=0.
- resetn=0 mid-HOLD in L2 -> next edge: level=000, reveal=000, moves=0, IDLE. 300 mismatched turns -> moves saturates at 255.
